// File: rtl/carbonio_pio_pattern_tx.sv
`default_nettype none
// ============================================================================
// carbonio_pio_pattern_tx : FIFO-fed timed pattern player for PIO output pins
// Rev 1.0
// ============================================================================
module carbonio_pio_pattern_tx #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int INTERVAL_W = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            pat_push,
  input  logic [WIDTH-1:0]                pat_wdata,
  input  logic                            flush,
  input  logic                            out_we,
  input  logic [WIDTH-1:0]                out_wdata,
  input  logic                            cfg_we,
  input  logic [INTERVAL_W-1:0]           interval_wdata,
  input  logic [WIDTH-1:0]                mask_wdata,
  input  logic                            err_clr,
  output logic [WIDTH-1:0]                pio_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pat_count,
  output logic                            pat_full,
  output logic                            busy,
  output logic                            word_pulse,
  output logic                            underflow,
  output logic                            overflow,
  output logic [INTERVAL_W-1:0]           interval,
  output logic [WIDTH-1:0]                mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INTERVAL_W-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]       pio_q, pio_d;
  logic [INTERVAL_W-1:0]  interval_q, interval_d;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pulse_q, pulse_d;
  logic                   underflow_q, underflow_d;
  logic                   overflow_q, overflow_d;
  logic [WIDTH-1:0]       mem_q [FIFO_DEPTH];

  logic                   full;
  logic                   empty;
  logic                   push_ok;
  logic                   load;
  logic                   uf_set;
  logic                   ovf_set;
  logic [WIDTH-1:0]       head;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = pat_push && !full && !flush;
  assign ovf_set = pat_push && full;

  // Playback sequencer; load doubles as the FIFO pop.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    load    = 1'b0;
    uf_set  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) load = 1'b1;
        end
        ST_HOLD: begin
          if (hold_q != '0) begin
            hold_d = hold_q - INTERVAL_W'(1);
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            uf_set  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (load) begin
        state_d = ST_HOLD;
        hold_d  = interval_q;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (load)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, load})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Direct write first, so a coinciding load overrides only the masked bits.
  always_comb begin
    pio_d = pio_q;
    if (out_we) pio_d = out_wdata;
    if (load)   pio_d = (pio_d & ~mask_q) | (head & mask_q);
    interval_d  = cfg_we ? interval_wdata : interval_q;
    mask_d      = cfg_we ? mask_wdata : mask_q;
    pulse_d     = load;
    underflow_d = uf_set  ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
    overflow_d  = ovf_set ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      pio_q       <= '0;
      interval_q  <= '0;
      mask_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pulse_q     <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      pio_q       <= pio_d;
      interval_q  <= interval_d;
      mask_q      <= mask_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pulse_q     <= pulse_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= pat_wdata;
  end

  assign pio_out    = pio_q;
  assign pat_count  = count_q;
  assign pat_full   = full;
  assign busy       = (state_q == ST_HOLD);
  assign word_pulse = pulse_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;
  assign interval   = interval_q;
  assign mask       = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_carbonio_pio_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_carbonio_pio_pattern_tx : directed vector bench for the PIO pattern player
// Rev 1.0
// ============================================================================
module tb_carbonio_pio_pattern_tx;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pat_push;
  logic [31:0] pat_wdata;
  logic        flush;
  logic        out_we;
  logic [31:0] out_wdata;
  logic        cfg_we;
  logic [15:0] interval_wdata;
  logic [31:0] mask_wdata;
  logic        err_clr;
  logic [31:0] pio_out;
  logic [4:0]  pat_count;
  logic        pat_full;
  logic        busy;
  logic        word_pulse;
  logic        underflow;
  logic        overflow;
  logic [15:0] interval;
  logic [31:0] mask;

  int n_cmp;
  int n_err;

  carbonio_pio_pattern_tx #(
    .WIDTH(32), .FIFO_DEPTH(16), .INTERVAL_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pat_push(pat_push),
    .pat_wdata(pat_wdata), .flush(flush), .out_we(out_we), .out_wdata(out_wdata),
    .cfg_we(cfg_we), .interval_wdata(interval_wdata), .mask_wdata(mask_wdata),
    .err_clr(err_clr), .pio_out(pio_out), .pat_count(pat_count), .pat_full(pat_full),
    .busy(busy), .word_pulse(word_pulse), .underflow(underflow), .overflow(overflow),
    .interval(interval), .mask(mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        push;
    logic [31:0] wd;
    logic        owe;
    logic [31:0] owd;
    logic        cwe;
    logic [15:0] iv;
    logic [31:0] mk;
    logic        eclr;
    logic [31:0] e_pio;
    int          e_cnt;
    logic        e_busy;
    logic        e_pulse;
    logic        e_uf;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic push, input logic [31:0] wd,
                     input logic owe, input logic [31:0] owd, input logic cwe,
                     input logic [15:0] iv, input logic [31:0] mk, input logic eclr,
                     input logic [31:0] e_pio, input int e_cnt, input logic e_busy,
                     input logic e_pulse, input logic e_uf, input logic e_ovf);
    vec_t v;
    v.en = en; v.push = push; v.wd = wd; v.owe = owe; v.owd = owd; v.cwe = cwe;
    v.iv = iv; v.mk = mk; v.eclr = eclr; v.e_pio = e_pio; v.e_cnt = e_cnt;
    v.e_busy = e_busy; v.e_pulse = e_pulse; v.e_uf = e_uf; v.e_ovf = e_ovf;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_pulses();
    pat_push = 1'b0; flush = 1'b0; out_we = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic cfg(input logic [15:0] iv, input logic [31:0] mk);
    cfg_we = 1'b1; interval_wdata = iv; mask_wdata = mk;
  endtask

  task automatic push(input logic [31:0] d);
    pat_push = 1'b1; pat_wdata = d;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; enable = 1'b0; pat_wdata = '0; out_wdata = '0;
    interval_wdata = '0; mask_wdata = '0;
    clear_pulses();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst pio", pio_out, 32'h0);
    chk("rst count", 32'(pat_count), 32'd0);
    chk("rst full", 32'(pat_full), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst pulse", 32'(word_pulse), 32'd0);
    chk("rst flags", {30'd0, underflow, overflow}, 32'd0);
    chk("rst cfg", {16'd0, interval} | mask, 32'd0);

    // interval=2 playback of three words, then masked and direct writes
    add(0,0,32'h0,0,32'h0,1,16'd2,32'hFFFF_FFFF,0, 32'h0,0,0,0,0,0);
    add(0,1,32'hA1,0,32'h0,0,16'd0,32'h0,0, 32'h0,1,0,0,0,0);
    add(0,1,32'hB2,0,32'h0,0,16'd0,32'h0,0, 32'h0,2,0,0,0,0);
    add(0,1,32'hC3,0,32'h0,0,16'd0,32'h0,0, 32'h0,3,0,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hA1,2,1,1,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hA1,2,1,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hA1,2,1,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hB2,1,1,1,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hB2,1,1,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hB2,1,1,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hC3,0,1,1,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hC3,0,1,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hC3,0,1,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'hC3,0,0,0,1,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,1, 32'hC3,0,0,0,0,0);
    add(0,0,32'h0,1,32'h0000_00FF,1,16'd0,32'h0000_FF00,0, 32'h0000_00FF,0,0,0,0,0);
    add(0,1,32'h1234_5678,0,32'h0,0,16'd0,32'h0,0, 32'h0000_00FF,1,0,0,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'h0000_56FF,0,1,1,0,0);
    add(1,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'h0000_56FF,0,0,0,1,0);
    add(0,0,32'h0,0,32'h0,0,16'd0,32'h0,1, 32'h0000_56FF,0,0,0,0,0);
    add(0,1,32'hAAAA_AAAA,0,32'h0,0,16'd0,32'h0,0, 32'h0000_56FF,1,0,0,0,0);
    add(1,0,32'h0,1,32'h1111_1111,0,16'd0,32'h0,0, 32'h1111_AA11,0,1,1,0,0);
    add(0,0,32'h0,0,32'h0,0,16'd0,32'h0,0, 32'h1111_AA11,0,0,0,0,0);

    foreach (tbl[i]) begin
      enable = tbl[i].en;
      pat_push = tbl[i].push; pat_wdata = tbl[i].wd;
      out_we = tbl[i].owe; out_wdata = tbl[i].owd;
      cfg_we = tbl[i].cwe; interval_wdata = tbl[i].iv; mask_wdata = tbl[i].mk;
      err_clr = tbl[i].eclr;
      cyc();
      chk($sformatf("v%0d pio", i), pio_out, tbl[i].e_pio);
      chk($sformatf("v%0d count", i), 32'(pat_count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d pulse", i), 32'(word_pulse), 32'(tbl[i].e_pulse));
      chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(tbl[i].e_uf));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // interval=0: sixteen back-to-back words
    enable = 1'b0; cfg(16'd0, 32'hFFFF_FFFF); cyc();
    chk("cfg interval", 32'(interval), 32'd0);
    chk("cfg mask", mask, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) begin push(32'h1000_0000 + i); cyc(); end
    chk("s2 full", 32'(pat_full), 32'd1);
    chk("s2 count", 32'(pat_count), 32'd16);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("s2 pio%0d", i), pio_out, 32'h1000_0000 + i);
      chk($sformatf("s2 pulse%0d", i), 32'(word_pulse), 32'd1);
      chk($sformatf("s2 count%0d", i), 32'(pat_count), 32'(15 - i));
    end
    cyc();
    chk("s2 underflow", 32'(underflow), 32'd1);
    chk("s2 busy", 32'(busy), 32'd0);
    chk("s2 pulse end", 32'(word_pulse), 32'd0);

    // overflow: 17th push dropped and never played
    enable = 1'b0; err_clr = 1'b1; cyc();
    chk("s3 uf clr", 32'(underflow), 32'd0);
    for (int i = 0; i < 16; i++) begin push(32'h2000_0000 + i); cyc(); end
    chk("s3 ovf before", 32'(overflow), 32'd0);
    push(32'h2DEA_D017); cyc();
    chk("s3 ovf", 32'(overflow), 32'd1);
    chk("s3 count", 32'(pat_count), 32'd16);
    chk("s3 full", 32'(pat_full), 32'd1);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("s3 pio%0d", i), pio_out, 32'h2000_0000 + i);
    end
    cyc();
    chk("s3 no 17th", pio_out, 32'h2000_000F);
    chk("s3 underflow", 32'(underflow), 32'd1);
    enable = 1'b0; err_clr = 1'b1; cyc();
    chk("s3 flags clr", {30'd0, underflow, overflow}, 32'd0);

    // enable dropped mid-HOLD, then resumed from the head
    cfg(16'd3, 32'hFFFF_FFFF); cyc();
    for (int i = 0; i < 6; i++) begin push(32'h3000_0000 + i); cyc(); end
    enable = 1'b1; cyc();
    chk("s4 load", pio_out, 32'h3000_0000);
    chk("s4 count", 32'(pat_count), 32'd5);
    cyc();
    chk("s4 busy", 32'(busy), 32'd1);
    enable = 1'b0; cyc();
    chk("s4 drop busy", 32'(busy), 32'd0);
    chk("s4 drop pio", pio_out, 32'h3000_0000);
    chk("s4 drop count", 32'(pat_count), 32'd5);
    chk("s4 drop uf", 32'(underflow), 32'd0);
    enable = 1'b1; cyc();
    chk("s4 resume pio", pio_out, 32'h3000_0001);
    chk("s4 resume pulse", 32'(word_pulse), 32'd1);
    chk("s4 resume count", 32'(pat_count), 32'd4);

    // flush with a same-cycle push
    enable = 1'b0; flush = 1'b1; push(32'h5555_5555); cyc();
    chk("s5 flush count", 32'(pat_count), 32'd0);
    chk("s5 flush pio", pio_out, 32'h3000_0001);
    enable = 1'b1; cyc();
    chk("s5 idle busy", 32'(busy), 32'd0);
    chk("s5 idle uf", 32'(underflow), 32'd0);
    chk("s5 idle pio", pio_out, 32'h3000_0001);

    // push-to-output latency, then asynchronous reset mid-playback
    cfg(16'd1, 32'hFFFF_FFFF); push(32'h4000_0001); cyc();
    chk("s6 latency hold", pio_out, 32'h3000_0001);
    chk("s6 latency count", 32'(pat_count), 32'd1);
    push(32'h4000_0002); cyc();
    chk("s6 latency load", pio_out, 32'h4000_0001);
    chk("s6 latency pulse", 32'(word_pulse), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6 rst pio", pio_out, 32'h0);
    chk("s6 rst busy", 32'(busy), 32'd0);
    chk("s6 rst pulse", 32'(word_pulse), 32'd0);
    chk("s6 rst count", 32'(pat_count), 32'd0);
    enable = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("s6 post count", 32'(pat_count), 32'd0);
    chk("s6 post pio", pio_out, 32'h0);
    chk("s6 post cfg", {16'd0, interval} | mask, 32'd0);
    chk("s6 post flags", {30'd0, underflow, overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
